// File: rtl/ws2811_receiver.sv
// WS2811 single-wire NRZ receiver: measures pulse widths in 100 ns ticks and assembles GRB words, MSB first.
// Optional pulse-width error checking is enabled by defining WS2811_RX_ERROR_EN.
module ws2811_receiver #(
    parameter int CLOCK_SPEED     = 50_000_000,
    parameter int THRESHOLD_100NS = 8,
    parameter int LATCH_100NS     = 500,
    parameter int MIN_HIGH_100NS  = 2,
    parameter int MAX_HIGH_100NS  = 20
) (
    input  logic        clkIN,
    input  logic        nResetIN,
    input  logic        rxIN,
    output logic [23:0] dataOUT,
    output logic        validOUT,
    output logic        latchOUT,
    output logic        busyOUT,
    output logic        errorOUT
);

`ifdef WS2811_RX_ERROR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    localparam int DIV = CLOCK_SPEED / 10_000_000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LW  = $clog2(LATCH_100NS + 1);

    localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
    localparam logic [LW-1:0] LATCH_V  = LW'(LATCH_100NS);
    localparam logic [4:0]    THR_V    = 5'(THRESHOLD_100NS);
    localparam logic [4:0]    MIN_V    = 5'(MIN_HIGH_100NS);
    localparam logic [4:0]    MAX_V    = 5'(MAX_HIGH_100NS);
    localparam logic [4:0]    HIGH_SAT = 5'd31;

    localparam logic [0:0] S_LOW  = 1'b0;
    localparam logic [0:0] S_HIGH = 1'b1;

    logic          rxMeta, rxSync, rxPrev;
    logic          rise, fall, tick;
    logic [PW-1:0] prescale;
    logic [0:0]    state;
    logic [4:0]    highCnt, highW, bitCnt;
    logic [LW-1:0] lowCnt;
    logic [22:0]   shift;
    logic          bitVal, widthBad, latchHit;

    assign rise = rxSync & ~rxPrev;
    assign fall = ~rxSync & rxPrev;
    assign tick = (prescale == PRE_MAX);

    // A tick landing on the falling-edge cycle completes the last 100 ns of the pulse, so count it.
    assign highW    = (tick && highCnt != HIGH_SAT) ? highCnt + 5'd1 : highCnt;
    assign bitVal   = (highW >= THR_V);
    assign widthBad = ERR_EN && ((highW < MIN_V) || (highW > MAX_V));
    assign latchHit = (state == S_LOW) && tick && (lowCnt == LATCH_V - LW'(1));
    assign busyOUT  = (bitCnt != 5'd0);

    always_ff @(negedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            rxMeta   <= 1'b0;
            rxSync   <= 1'b0;
            rxPrev   <= 1'b0;
            prescale <= '0;
            state    <= S_LOW;
            highCnt  <= '0;
            lowCnt   <= LATCH_V;
            bitCnt   <= '0;
            shift    <= '0;
            dataOUT  <= '0;
            validOUT <= 1'b0;
            latchOUT <= 1'b0;
            errorOUT <= 1'b0;
        end else begin
            rxMeta   <= rxIN;
            rxSync   <= rxMeta;
            rxPrev   <= rxSync;
            validOUT <= 1'b0;
            latchOUT <= 1'b0;

            if (rise || fall || tick) prescale <= '0;
            else                      prescale <= prescale + PW'(1);

            if (state == S_LOW) begin
                if (tick && lowCnt != LATCH_V) lowCnt <= lowCnt + LW'(1);
                // Latch is reported even if a rising edge arrives on the same cycle.
                if (latchHit) begin
                    latchOUT <= 1'b1;
                    bitCnt   <= '0;
                    errorOUT <= 1'b0;
                end
                if (rise) begin
                    state   <= S_HIGH;
                    highCnt <= '0;
                end
            end else begin
                if (fall) begin
                    state  <= S_LOW;
                    lowCnt <= '0;
                    if (widthBad) begin
                        errorOUT <= 1'b1;
                        bitCnt   <= '0;
                    end else if (bitCnt == 5'd23) begin
                        dataOUT  <= {shift, bitVal};
                        validOUT <= 1'b1;
                        bitCnt   <= '0;
                    end else begin
                        shift  <= {shift[21:0], bitVal};
                        bitCnt <= bitCnt + 5'd1;
                    end
                end else if (tick && highCnt != HIGH_SAT) begin
                    highCnt <= highCnt + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ws2811_receiver.sv
// Bench for ws2811_receiver: pulse-level driver feeding an event model, checked against the DUT every clkIN cycle.
module tb_ws2811_receiver;

`ifdef WS2811_RX_ERROR_EN
    localparam bit TB_ERR = 1'b1;
`else
    localparam bit TB_ERR = 1'b0;
`endif

    // 50 MHz clock: 5 cycles per 100 ns tick, 2500 cycles per 50 us latch gap, 3-cycle output latency.
    localparam int LAT       = 3;
    localparam int LATCH_CYC = 2500;

    logic        clkIN = 1'b0;
    logic        nResetIN = 1'b1;
    logic        rxIN = 1'b0;
    logic [23:0] dataOUT;
    logic        validOUT, latchOUT, busyOUT, errorOUT;

    always #10 clkIN = ~clkIN;

    ws2811_receiver dut (
        .clkIN   (clkIN),
        .nResetIN(nResetIN),
        .rxIN    (rxIN),
        .dataOUT (dataOUT),
        .validOUT(validOUT),
        .latchOUT(latchOUT),
        .busyOUT (busyOUT),
        .errorOUT(errorOUT)
    );

    typedef struct {
        int          t;
        int          bits;
        bit          word;
        logic [23:0] data;
        bit          err;
    } ev_t;

    ev_t         evq[$];
    int          cyc = 0, errors = 0, checks = 0;
    int          modelBits = 0, fallCyc = 0, nb = 0;
    int          validCount = 0, latchCount = 0;
    logic [23:0] expData = '0, acc = '0;
    bit          expErr = 1'b0, armed = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clkIN);
            cyc++;
        end
    endtask

    task automatic pushEv(input bit word, input logic [23:0] d, input bit err);
        ev_t e;
        e.t = cyc + LAT; e.bits = nb; e.word = word; e.data = d; e.err = err;
        evq.push_back(e);
    endtask

    // kind: 0 = data bit 0, 1 = data bit 1, 2 = short glitch
    task automatic pulse(input int hi, input int lo, input int kind);
        rxIN = 1'b1; armed = 1'b0;
        step(hi);
        rxIN = 1'b0; fallCyc = cyc; armed = 1'b1;
        if (kind == 2 && TB_ERR) begin
            nb = 0;
            pushEv(1'b0, '0, 1'b1);
        end else begin
            acc = {acc[22:0], (kind == 1)};
            nb++;
            if (nb == 24) begin
                nb = 0;
                pushEv(1'b1, acc, 1'b0);
            end else begin
                pushEv(1'b0, '0, 1'b0);
            end
        end
        step(lo);
    endtask

    task automatic sendBit(input bit b);
        if (b) pulse(60, 65, 1);
        else   pulse(25, 100, 0);
    endtask

    task automatic sendWord(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) sendBit(w[i]);
    endtask

    task automatic longGap(input int n);
        nb = 0;
        step(n);
    endtask

    task automatic doReset(input int n);
        evq.delete();
        modelBits = 0; expData = '0; expErr = 1'b0; armed = 1'b0; nb = 0;
        nResetIN = 1'b0;
        step(n);
        chk("rst_data", dataOUT, 0);
        chk("rst_busy", busyOUT, 0);
        chk("rst_valid", validOUT, 0);
        chk("rst_latch", latchOUT, 0);
        chk("rst_err", errorOUT, 0);
        nResetIN = 1'b1;
    endtask

    always @(posedge clkIN) begin : cmp
        logic expValid, expLatch;
        #2;
        expValid = 1'b0;
        expLatch = 1'b0;
        while (evq.size() > 0 && evq[0].t <= cyc) begin
            modelBits = evq[0].bits;
            if (evq[0].word) begin
                expValid = 1'b1;
                expData  = evq[0].data;
            end
            if (evq[0].err) expErr = 1'b1;
            void'(evq.pop_front());
        end
        if (armed && cyc == fallCyc + LAT + LATCH_CYC) begin
            expLatch  = 1'b1;
            modelBits = 0;
            expErr    = 1'b0;
        end
        if (validOUT === 1'b1) validCount++;
        if (latchOUT === 1'b1) latchCount++;
        chk("valid", validOUT, expValid);
        chk("latch", latchOUT, expLatch);
        chk("busy", busyOUT, modelBits != 0);
        chk("data", dataOUT, expData);
        chk("error", errorOUT, expErr);
    end

    initial begin
        #1 nResetIN = 1'b0;
        doReset(5);

        // Idle after reset: the saturated low counter must not produce a latch.
        step(5000);
        chk("idle_latch_cnt", latchCount, 0);
        chk("idle_valid_cnt", validCount, 0);
        chk("idle_data", dataOUT, 0);

        sendWord(24'hA5C3F0);
        step(200);
        chk("loop_valid_cnt", validCount, 1);
        chk("loop_data", dataOUT, 24'hA5C3F0);
        chk("loop_busy", busyOUT, 0);

        sendWord(24'h000001);
        sendWord(24'hFFFFFF);
        longGap(3000);
        chk("b2b_valid_cnt", validCount, 3);
        chk("b2b_latch_cnt", latchCount, 1);
        chk("b2b_data", dataOUT, 24'hFFFFFF);

        for (int i = 9; i >= 0; i--) sendBit(i[0] ? 1'b1 : 1'b0);
        chk("partial_busy", busyOUT, 1);
        longGap(3000);
        chk("partial_busy_after_latch", busyOUT, 0);
        sendWord(24'h123456);
        step(200);
        chk("partial_latch_cnt", latchCount, 2);
        chk("partial_valid_cnt", validCount, 4);
        chk("partial_data", dataOUT, 24'h123456);

        for (int i = 0; i < 12; i++) sendBit(i[1]);
        doReset(5);
        step(10);
        sendWord(24'h0F0F0F);
        step(200);
        chk("rst_mid_valid_cnt", validCount, 5);
        chk("rst_mid_data", dataOUT, 24'h0F0F0F);

        for (int i = 0; i < 8; i++) sendBit(i[0]);
        pulse(5, 100, 2);
        chk("glitch_err", errorOUT, TB_ERR);
        chk("glitch_busy", busyOUT, TB_ERR ? 0 : 1);
        for (int i = 0; i < 8; i++) sendBit(i[0]);
        longGap(3000);
        chk("glitch_err_cleared", errorOUT, 0);
        chk("glitch_latch_cnt", latchCount, 3);
        chk("glitch_valid_cnt", validCount, 5);
        sendWord(24'h00FF00);
        step(200);
        chk("glitch_word_valid_cnt", validCount, 6);
        chk("glitch_word_data", dataOUT, 24'h00FF00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
